// File: rtl/tlb_lookup_arb.sv
// Three-way TLB lookup arbiter (search > dcache > icache, with icache anti-starvation)
// sharing one lookup port, plus sequencing of TLB write requests around in-flight lookups.
`timescale 1ns/1ps
module tlb_lookup_arb #(
  parameter int STARVE_LIM = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_req,
  input  logic [18:0] s_vppn,
  input  logic        d_req,
  input  logic [31:0] d_vaddr,
  input  logic        i_req,
  input  logic [31:0] i_vaddr,
  output logic        s_ready,
  output logic        d_ready,
  output logic        i_ready,
  output logic        s_rvalid,
  output logic        d_rvalid,
  output logic        i_rvalid,
  output logic [31:0] d_paddr,
  output logic [31:0] i_paddr,
  output logic        d_hit,
  output logic        i_hit,
  output logic        s_hit,
  output logic [4:0]  s_index,
  input  logic        w_req,
  output logic        w_done,
  output logic        tlb_we,
  input  logic        flush,
  output logic        lk_valid,
  output logic [18:0] lk_vppn,
  output logic        lk_odd,
  input  logic        lk_hit,
  input  logic [19:0] lk_ppn,
  input  logic [4:0]  lk_index
);

  localparam int CNT_W = ($clog2(STARVE_LIM + 1) < 2) ? 2 : $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIM);

  typedef enum logic [1:0] {IDLE, BUSY, WDRAIN, WRITE} state_t;
  typedef enum logic [1:0] {RQ_S, RQ_D, RQ_I} rq_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_vld_q, rsp_vld_d;
  rq_t              rsp_id_q, rsp_id_d;
  logic [11:0]      vbuf_q, vbuf_d;

  logic s_gnt, d_gnt, i_gnt, gnt_any;
  logic accept_ok, i_elig, force_i;
  logic [31:0] rsp_paddr;

  always_comb begin
    // A pending write blocks new lookups, and the ready gating keeps outputs quiet in reset.
    accept_ok = rst && !w_req && (state_q == IDLE || state_q == BUSY);
    i_elig    = i_req && !flush;
    force_i   = i_elig && (cnt_q == CNT_MAX);
    s_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_gnt     = 1'b0;
    if (accept_ok) begin
      if (force_i)     i_gnt = 1'b1;
      else if (s_req)  s_gnt = 1'b1;
      else if (d_req)  d_gnt = 1'b1;
      else if (i_elig) i_gnt = 1'b1;
    end
    gnt_any = s_gnt || d_gnt || i_gnt;

    // Counter keeps counting through flush-blocked cycles so the icache still gets its turn.
    if (!i_req || i_gnt)      cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    else                       cnt_d = cnt_q;

    state_d = state_q;
    case (state_q)
      IDLE:    state_d = gnt_any ? BUSY : (w_req ? WRITE : IDLE);
      BUSY:    state_d = w_req ? WDRAIN : (gnt_any ? BUSY : IDLE);
      WDRAIN:  state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rsp_vld_d = gnt_any;
    rsp_id_d  = s_gnt ? RQ_S : (d_gnt ? RQ_D : RQ_I);
    vbuf_d    = d_gnt ? d_vaddr[11:0] : (i_gnt ? i_vaddr[11:0] : 12'h0);
  end

  always_comb begin
    s_ready  = s_gnt;
    d_ready  = d_gnt;
    i_ready  = i_gnt;
    lk_valid = gnt_any;
    lk_vppn  = 19'h0;
    lk_odd   = 1'b0;
    if (s_gnt) begin
      lk_vppn = s_vppn;
    end else if (d_gnt) begin
      lk_vppn = d_vaddr[31:13];
      lk_odd  = d_vaddr[12];
    end else if (i_gnt) begin
      lk_vppn = i_vaddr[31:13];
      lk_odd  = i_vaddr[12];
    end
  end

  always_comb begin
    s_rvalid  = rsp_vld_q && (rsp_id_q == RQ_S);
    d_rvalid  = rsp_vld_q && (rsp_id_q == RQ_D);
    i_rvalid  = rsp_vld_q && (rsp_id_q == RQ_I) && !flush;
    rsp_paddr = lk_hit ? {lk_ppn, vbuf_q} : 32'h0;
    s_hit     = s_rvalid && lk_hit;
    s_index   = (s_rvalid && lk_hit) ? lk_index : 5'h0;
    d_hit     = d_rvalid && lk_hit;
    d_paddr   = d_rvalid ? rsp_paddr : 32'h0;
    i_hit     = i_rvalid && lk_hit;
    i_paddr   = i_rvalid ? rsp_paddr : 32'h0;
    tlb_we    = (state_q == WRITE);
    w_done    = (state_q == WRITE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= RQ_S;
      vbuf_q    <= 12'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
      vbuf_q    <= vbuf_d;
    end
  end

endmodule

// File: tb/tb_tlb_lookup_arb.sv
// Bench for tlb_lookup_arb: per-cycle grant table, response scoreboard driven by a
// small TLB model, and directed reset / literal-value sequences.
`timescale 1ns/1ps
module tb_tlb_lookup_arb;

  logic        clk, rst;
  logic        s_req, d_req, i_req, w_req, flush;
  logic [18:0] s_vppn;
  logic [31:0] d_vaddr, i_vaddr;
  logic        s_ready, d_ready, i_ready, s_rvalid, d_rvalid, i_rvalid;
  logic [31:0] d_paddr, i_paddr;
  logic        d_hit, i_hit, s_hit;
  logic [4:0]  s_index;
  logic        w_done, tlb_we, lk_valid, lk_odd;
  logic [18:0] lk_vppn;
  logic        lk_hit;
  logic [19:0] lk_ppn;
  logic [4:0]  lk_index;

  tlb_lookup_arb #(.STARVE_LIM(3)) dut (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_vppn(s_vppn), .d_req(d_req), .d_vaddr(d_vaddr),
    .i_req(i_req), .i_vaddr(i_vaddr),
    .s_ready(s_ready), .d_ready(d_ready), .i_ready(i_ready),
    .s_rvalid(s_rvalid), .d_rvalid(d_rvalid), .i_rvalid(i_rvalid),
    .d_paddr(d_paddr), .i_paddr(i_paddr), .d_hit(d_hit), .i_hit(i_hit),
    .s_hit(s_hit), .s_index(s_index),
    .w_req(w_req), .w_done(w_done), .tlb_we(tlb_we), .flush(flush),
    .lk_valid(lk_valid), .lk_vppn(lk_vppn), .lk_odd(lk_odd),
    .lk_hit(lk_hit), .lk_ppn(lk_ppn), .lk_index(lk_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       s, d, i, w, f;
    logic [2:0] rdy;   // expected {s_ready, d_ready, i_ready}
    logic       we;
  } vec_t;

  typedef struct {
    int          due;
    logic [1:0]  id;   // 0 search, 1 dcache, 2 icache
    logic [18:0] vppn;
    logic        odd;
    logic [11:0] lo;
  } rec_t;

  vec_t tbl [35];
  rec_t sb [$];
  int   n_chk = 0, n_pass = 0, cyc = 0;

  logic        cap_v, cap_odd;
  logic [18:0] cap_vppn;
  logic        smp_s_rvalid, smp_s_hit, smp_d_rvalid, smp_d_hit;
  logic [4:0]  smp_s_index;
  logic [31:0] smp_d_paddr;

  // Reference TLB contents: hit unless vppn[1:0]==0, ppn is a fixed scramble of {vppn, odd}.
  function automatic logic m_hit(input logic [18:0] v);
    return v[1:0] != 2'b00;
  endfunction

  function automatic logic [19:0] m_ppn(input logic [18:0] v, input logic o);
    return {1'b0, v} ^ 20'h016C6 ^ {19'd0, o};
  endfunction

  function automatic vec_t mk(input logic [4:0] sdiwf, input logic [2:0] rdy, input logic we);
    vec_t v;
    v.s = sdiwf[4]; v.d = sdiwf[3]; v.i = sdiwf[2]; v.w = sdiwf[1]; v.f = sdiwf[0];
    v.rdy = rdy; v.we = we;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick(input logic s, d, i, w, f, input logic [2:0] rdy, input logic we,
                      input string nm, input int k);
    logic [18:0] sv;
    logic [31:0] dv, iv;
    logic [74:0] exp_r, act_r;
    logic        h;
    rec_t        r;
    sv = 19'(32'h0ABC + 32'(k) * 32'h111);
    dv = 32'h1234_5ABC + 32'(k) * 32'h0001_2345;
    iv = 32'h0040_3123 + 32'(k) * 32'h0002_7531;
    s_req = s; d_req = d; i_req = i; w_req = w; flush = f;
    s_vppn = sv; d_vaddr = dv; i_vaddr = iv;
    @(negedge clk);
    chk({nm, "_ctl"}, 128'({s_ready, d_ready, i_ready, lk_valid, tlb_we, w_done}),
        128'({rdy, |rdy, we, we}));
    exp_r = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      r = sb.pop_front();
      h = m_hit(r.vppn);
      case (r.id)
        2'd0: exp_r[74:68] = {1'b1, h, h ? r.vppn[4:0] : 5'h0};
        2'd1: exp_r[67:34] = {1'b1, h, h ? {m_ppn(r.vppn, r.odd), r.lo} : 32'h0};
        default: if (!f) exp_r[33:0] = {1'b1, h, h ? {m_ppn(r.vppn, r.odd), r.lo} : 32'h0};
      endcase
    end
    act_r = {s_rvalid, s_hit, s_index, d_rvalid, d_hit, d_paddr, i_rvalid, i_hit, i_paddr};
    chk({nm, "_rsp"}, 128'(act_r), 128'(exp_r));
    if (rdy != 3'b000) begin
      r.due = cyc + 1;
      if (rdy[2]) begin
        r.id = 2'd0; r.vppn = sv; r.odd = 1'b0; r.lo = 12'h0;
      end else if (rdy[1]) begin
        r.id = 2'd1; r.vppn = dv[31:13]; r.odd = dv[12]; r.lo = dv[11:0];
      end else begin
        r.id = 2'd2; r.vppn = iv[31:13]; r.odd = iv[12]; r.lo = iv[11:0];
      end
      sb.push_back(r);
    end
    cap_v = lk_valid; cap_vppn = lk_vppn; cap_odd = lk_odd;
    smp_s_rvalid = s_rvalid; smp_s_hit = s_hit; smp_s_index = s_index;
    smp_d_rvalid = d_rvalid; smp_d_hit = d_hit; smp_d_paddr = d_paddr;
    @(posedge clk);
    #1;
    if (cap_v) begin
      lk_hit = m_hit(cap_vppn); lk_ppn = m_ppn(cap_vppn, cap_odd); lk_index = cap_vppn[4:0];
    end else begin
      lk_hit = 1'($urandom); lk_ppn = 20'($urandom); lk_index = 5'($urandom);
    end
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(5'b01000, 3'b010, 1'b0);
    tbl[1]  = mk(5'b00000, 3'b000, 1'b0);
    tbl[2]  = mk(5'b10000, 3'b100, 1'b0);
    tbl[3]  = mk(5'b00100, 3'b001, 1'b0);
    tbl[4]  = mk(5'b01100, 3'b010, 1'b0);
    tbl[5]  = mk(5'b01100, 3'b010, 1'b0);
    tbl[6]  = mk(5'b01100, 3'b010, 1'b0);
    tbl[7]  = mk(5'b01100, 3'b001, 1'b0);
    tbl[8]  = mk(5'b11100, 3'b100, 1'b0);
    tbl[9]  = mk(5'b11100, 3'b100, 1'b0);
    tbl[10] = mk(5'b11100, 3'b100, 1'b0);
    tbl[11] = mk(5'b11100, 3'b001, 1'b0);
    tbl[12] = mk(5'b11100, 3'b100, 1'b0);
    tbl[13] = mk(5'b01100, 3'b010, 1'b0);
    tbl[14] = mk(5'b01100, 3'b010, 1'b0);
    tbl[15] = mk(5'b01100, 3'b001, 1'b0);
    tbl[16] = mk(5'b00100, 3'b001, 1'b0);
    tbl[17] = mk(5'b01001, 3'b010, 1'b0);  // flush kills the icache response, dcache still accepted
    tbl[18] = mk(5'b00101, 3'b000, 1'b0);
    tbl[19] = mk(5'b10101, 3'b100, 1'b0);
    tbl[20] = mk(5'b01100, 3'b010, 1'b0);
    tbl[21] = mk(5'b01101, 3'b010, 1'b0);
    tbl[22] = mk(5'b01100, 3'b001, 1'b0);
    tbl[23] = mk(5'b01000, 3'b010, 1'b0);
    tbl[24] = mk(5'b01010, 3'b000, 1'b0);
    tbl[25] = mk(5'b01010, 3'b000, 1'b0);
    tbl[26] = mk(5'b01010, 3'b000, 1'b1);
    tbl[27] = mk(5'b01000, 3'b010, 1'b0);
    tbl[28] = mk(5'b00100, 3'b001, 1'b0);
    tbl[29] = mk(5'b00000, 3'b000, 1'b0);
    tbl[30] = mk(5'b10110, 3'b000, 1'b0);
    tbl[31] = mk(5'b10110, 3'b000, 1'b1);
    tbl[32] = mk(5'b10100, 3'b100, 1'b0);
    tbl[33] = mk(5'b10100, 3'b001, 1'b0);
    tbl[34] = mk(5'b00000, 3'b000, 1'b0);

    cap_v = 1'b0; cap_vppn = '0; cap_odd = 1'b0;
    rst = 1'b0;
    s_req = 1'b1; d_req = 1'b1; i_req = 1'b1; w_req = 1'b1; flush = 1'b0;
    s_vppn = 19'h1; d_vaddr = 32'hFFFF_FFFF; i_vaddr = 32'hFFFF_FFFF;
    lk_hit = 1'b1; lk_ppn = 20'hFFFFF; lk_index = 5'h1F;
    #12;
    chk("reset_ctl", 128'({s_ready, d_ready, i_ready, lk_valid, tlb_we, w_done}), 128'(0));
    chk("reset_rsp", 128'({s_rvalid, s_hit, s_index, d_rvalid, d_hit, d_paddr,
                           i_rvalid, i_hit, i_paddr}), 128'(0));
    @(posedge clk);
    #1;
    s_req = 1'b0; d_req = 1'b0; i_req = 1'b0; w_req = 1'b0;
    rst = 1'b1;

    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, "dhit_acc", 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, "dhit_rsp", 0);
    chk("dhit_rvalid", 128'(smp_d_rvalid), 128'(1));
    chk("dhit_paddr", 128'(smp_d_paddr), 128'(32'h0876_5ABC));
    chk("dhit_hit", 128'(smp_d_hit), 128'(1));

    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, "smiss_acc", 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, "smiss_rsp", 0);
    chk("smiss_rvalid", 128'(smp_s_rvalid), 128'(1));
    chk("smiss_hit", 128'(smp_s_hit), 128'(0));
    chk("smiss_index", 128'(smp_s_index), 128'(0));

    for (int n = 0; n < 35; n++)
      tick(tbl[n].s, tbl[n].d, tbl[n].i, tbl[n].w, tbl[n].f, tbl[n].rdy, tbl[n].we,
           $sformatf("row%0d", n), n + 1);

    // Reset in the response cycle of a dcache lookup must drop the result at once.
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, "rstmid_acc", 5);
    #1;
    chk("rstmid_pre", 128'(d_rvalid), 128'(1));
    s_req = 1'b1; d_req = 1'b1; i_req = 1'b1;
    rst = 1'b0;
    #1;
    chk("rstmid_ctl", 128'({s_ready, d_ready, i_ready, lk_valid, tlb_we, w_done}), 128'(0));
    chk("rstmid_rsp", 128'({s_rvalid, s_hit, s_index, d_rvalid, d_hit, d_paddr,
                            i_rvalid, i_hit, i_paddr}), 128'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    s_req = 1'b0; d_req = 1'b0; i_req = 1'b0;
    rst = 1'b1;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, "postrst_acc", 6);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, "postrst_rsp", 6);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, "postrst_idle", 7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
